adder_seq_checker: RTL

- Self-checking traffic generator for the registered 4-bit add/sub unit. Drives its operand, carry, enable and mode inputs, samples its registered Q/RCO outputs and compares them against an internal reference model.
- Sits beside the adder in the test and bring-up wrapper.
- Runs one exhaustive sweep per START pulse and reports pass/fail, error count and the index of the first failing vector.

---
 rtl/adder_seq_checker.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adder_seq_checker.sv
// Exhaustive stimulus/check sequencer for the registered 4-bit add/sub unit.
// Issues one vector per cycle and compares the adder response two edges later.
module adder_seq_checker #(
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             CIN,
    output logic             ENB,
    output logic [1:0]       MODO,
    input  logic [3:0]       Q,
    input  logic             RCO,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [10:0]      FIRST_FAIL_IDX
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SUB   = 3'd3,
        S_HOLD  = 3'd4,
        S_ENOFF = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Reference adder: {carry/borrow, result} after applying one vector.
    function automatic logic [4:0] ref_step(input logic [4:0] prev, input logic [1:0] mode,
                                            input logic enb, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        logic [4:0] r;
        r = prev;
        if (enb) begin
            case (mode)
                2'b01:   r = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
                2'b10:   r = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
                2'b11:   r = 5'd0;
                default: r = prev;
            endcase
        end else begin
            r = prev;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [10:0]        idx_q, idx_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d, enb_q, enb_d;
    logic [1:0]         modo_q, modo_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [10:0]        ffi_q, ffi_d;
    logic [4:0]         exp_q, exp_d;
    logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [4:0]         s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
    logic [10:0]        s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic               issue_s, mismatch_s;

    // Sequencer, reference model, check pipeline and result accounting.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        enb_d     = enb_q;
        modo_d    = modo_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        ffi_d     = ffi_q;
        exp_d     = exp_q;
        s1_vld_d  = 1'b0;
        s1_exp_d  = s1_exp_q;
        s1_idx_d  = s1_idx_q;
        s2_vld_d  = s1_vld_q;
        s2_exp_d  = s1_exp_q;
        s2_idx_d  = s1_idx_q;
        issue_s   = 1'b0;

        mismatch_s = s2_vld_q && ({RCO, Q} != s2_exp_q);
        if (mismatch_s) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == '0) begin
                ffi_d = s2_idx_q;
            end else begin
                ffi_d = ffi_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        // In ADD/SUB the next operand triple equals the low 9 bits of the current index.
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d   = S_CLR;
                    idx_d     = 11'd0;
                    {a_d, b_d, cin_d} = 9'd0;
                    modo_d    = 2'b11;
                    enb_d     = 1'b1;
                    issue_s   = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    ffi_d     = 11'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_CLR: begin
                state_d = S_ADD;
                idx_d   = idx_q + 11'd1;
                {a_d, b_d, cin_d} = 9'd0;
                modo_d  = 2'b01;
                enb_d   = 1'b1;
                issue_s = 1'b1;
            end
            S_ADD: begin
                idx_d   = idx_q + 11'd1;
                issue_s = 1'b1;
                enb_d   = 1'b1;
                {a_d, b_d, cin_d} = idx_q[8:0];
                if (idx_q == 11'd512) begin
                    state_d = S_SUB;
                    modo_d  = 2'b10;
                end else begin
                    modo_d  = 2'b01;
                end
            end
            S_SUB: begin
                idx_d   = idx_q + 11'd1;
                issue_s = 1'b1;
                enb_d   = 1'b1;
                if (idx_q == 11'd1024) begin
                    state_d = S_HOLD;
                    {a_d, b_d, cin_d} = 9'h1FF;
                    modo_d  = 2'b00;
                end else begin
                    {a_d, b_d, cin_d} = idx_q[8:0];
                    modo_d  = 2'b10;
                end
            end
            S_HOLD: begin
                state_d = S_ENOFF;
                idx_d   = idx_q + 11'd1;
                {a_d, b_d, cin_d} = 9'h1FF;
                modo_d  = 2'b01;
                enb_d   = 1'b0;
                issue_s = 1'b1;
            end
            S_ENOFF: begin
                state_d = S_DRAIN;
                modo_d  = 2'b00;
                enb_d   = 1'b0;
            end
            S_DRAIN: begin
                modo_d = 2'b00;
                enb_d  = 1'b0;
                if (!s1_vld_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_s) begin
            exp_d    = ref_step(exp_q, modo_d, enb_d, a_d, b_d, cin_d);
            s1_vld_d = 1'b1;
            s1_exp_d = exp_d;
            s1_idx_d = idx_d;
        end else begin
            exp_d = exp_q;
        end

        if (STOP_ON_ERR && mismatch_s) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = 1'b0;
            enb_d    = 1'b0;
            modo_d   = 2'b00;
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            s2_vld_d = s2_vld_d;
        end
    end

    // State, driver and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            idx_q     <= 11'd0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            cin_q     <= 1'b0;
            enb_q     <= 1'b0;
            modo_q    <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            ffi_q     <= 11'd0;
            exp_q     <= 5'd0;
            s1_vld_q  <= 1'b0;
            s1_exp_q  <= 5'd0;
            s1_idx_q  <= 11'd0;
            s2_vld_q  <= 1'b0;
            s2_exp_q  <= 5'd0;
            s2_idx_q  <= 11'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            enb_q     <= enb_d;
            modo_q    <= modo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            ffi_q     <= ffi_d;
            exp_q     <= exp_d;
            s1_vld_q  <= s1_vld_d;
            s1_exp_q  <= s1_exp_d;
            s1_idx_q  <= s1_idx_d;
            s2_vld_q  <= s2_vld_d;
            s2_exp_q  <= s2_exp_d;
            s2_idx_q  <= s2_idx_d;
        end
    end

    assign A              = a_q;
    assign B              = b_q;
    assign CIN            = cin_q;
    assign ENB            = enb_q;
    assign MODO           = modo_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign ERR_CNT        = err_cnt_q;
    assign FIRST_FAIL_IDX = ffi_q;

endmodule
